// File: rtl/rst_seq_ctrl_if.sv
// rtl/rst_seq_ctrl_if.sv - request, channel-reset and status bundle of the reset sequencer
interface rst_seq_ctrl_if #(
  parameter int NUM_CH  = 4,
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ-1:0] REQ_IN;
  logic [NUM_REQ-1:0] REQ_MASK;
  logic               SW_RST;
  logic               CAUSE_CLR;
  logic [NUM_CH-1:0]  CH_RST;
  logic               SEQ_BUSY;
  logic [NUM_REQ+1:0] RST_CAUSE;

  modport master (
    output REQ_IN, REQ_MASK, SW_RST, CAUSE_CLR,
    input  CH_RST, SEQ_BUSY, RST_CAUSE
  );

  modport slave (
    input  REQ_IN, REQ_MASK, SW_RST, CAUSE_CLR,
    output CH_RST, SEQ_BUSY, RST_CAUSE
  );
endinterface

// File: rtl/rst_seq_ctrl.sv
// rtl/rst_seq_ctrl.sv - staged release of domain resets with filtered hw/sw reset requests
module rst_seq_ctrl #(
  parameter int NUM_STAGES = 2,
  parameter int NUM_CH     = 4,
  parameter int NUM_REQ    = 2,
  parameter int MIN_PULSE  = 3,
  parameter int HOLD_CYC   = 8,
  parameter int STEP_DLY   = 4
) (
  input  logic         CLK,
  input  logic         RST,
  rst_seq_ctrl_if.slave bus
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PC_W  = $clog2(MIN_PULSE + 1);

  typedef enum logic [1:0] {HOLD, RELEASE, RUN} state_t;

  state_t             state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [NUM_CH-1:0]  ch_q, ch_d;
  logic [NUM_REQ+1:0] cause_q, cause_d;
  logic               sw_q;
  logic [NUM_REQ-1:0] acc_vec;
  logic [NUM_REQ-1:0] hit;
  logic               trig;

  // Each request bit: synchronizer, run-length counter, one-shot accept flag
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
    logic [NUM_STAGES-1:0] sync;
    logic [PC_W-1:0]       pcnt;
    logic                  acc;

    always_ff @(posedge CLK) begin
      if (!RST) begin
        sync <= '0;
        pcnt <= '0;
        acc  <= 1'b0;
      end else begin
        sync <= {sync[NUM_STAGES-2:0], bus.REQ_IN[i]};
        if (!sync[NUM_STAGES-1])
          pcnt <= '0;
        else if (pcnt != PC_W'(MIN_PULSE))
          pcnt <= pcnt + 1'b1;
        acc <= sync[NUM_STAGES-1] && (pcnt == PC_W'(MIN_PULSE - 1));
      end
    end

    assign acc_vec[i] = acc;
  end

  assign hit  = acc_vec & ~bus.REQ_MASK;
  assign trig = sw_q | (|hit);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    ch_d    = ch_q;
    cause_d = bus.CAUSE_CLR ? '0 : cause_q;
    if (trig) begin
      cause_d = cause_d | {hit, sw_q, 1'b0};
      state_d = HOLD;
      cnt_d   = '0;
      idx_d   = '0;
      ch_d    = '0;
    end else begin
      case (state_q)
        HOLD: begin
          if (cnt_q == 8'(HOLD_CYC - 1)) begin
            state_d = RELEASE;
            cnt_d   = '0;
            idx_d   = '0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        RELEASE: begin
          if (cnt_q == 8'(STEP_DLY - 1)) begin
            ch_d[idx_q] = 1'b1;
            cnt_d       = '0;
            if (idx_q == IDX_W'(NUM_CH - 1))
              state_d = RUN;
            else
              idx_d = idx_q + 1'b1;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        RUN:     state_d = RUN;
        default: state_d = HOLD;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= HOLD;
      cnt_q   <= '0;
      idx_q   <= '0;
      ch_q    <= '0;
      cause_q <= {{(NUM_REQ + 1){1'b0}}, 1'b1};
      sw_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      ch_q    <= ch_d;
      cause_q <= cause_d;
      sw_q    <= bus.SW_RST;
    end
  end

  assign bus.CH_RST    = ch_q;
  assign bus.SEQ_BUSY  = (state_q != RUN);
  assign bus.RST_CAUSE = cause_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// tb/tb_rst_seq_ctrl.sv - self-checking bench for rst_seq_ctrl
module tb_rst_seq_ctrl;

  localparam int NS   = 2;
  localparam int NCH  = 4;
  localparam int NREQ = 2;
  localparam int MP   = 3;
  localparam int HOLD = 8;
  localparam int STEP = 4;
  localparam int D    = NS + MP + 1;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  rst_seq_ctrl_if #(.NUM_CH(NCH), .NUM_REQ(NREQ)) bus ();

  rst_seq_ctrl #(
    .NUM_STAGES(NS), .NUM_CH(NCH), .NUM_REQ(NREQ),
    .MIN_PULSE(MP), .HOLD_CYC(HOLD), .STEP_DLY(STEP)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: outputs follow from distance to the last sequence start; requests from a sample window
  bit              hist [NREQ][D];
  int              edge_no = 0;
  int              seq_start = 0;
  bit              model_valid = 0;
  bit              pend_sw = 0;
  bit [NREQ-1:0]   pend_acc = '0;
  bit [NREQ+1:0]   m_cause = '0;
  bit [NREQ-1:0]   m_hit;
  bit              m_run;

  always @(posedge CLK) begin
    if (!RST) begin
      seq_start   = edge_no;
      m_cause     = 1;
      pend_sw     = 0;
      pend_acc    = '0;
      model_valid = 1;
      for (int i = 0; i < NREQ; i++)
        for (int j = 0; j < D; j++) hist[i][j] = 0;
    end else begin
      m_hit = pend_acc & ~bus.REQ_MASK;
      if (bus.CAUSE_CLR) m_cause = '0;
      if (pend_sw || m_hit != 0) begin
        m_cause   = m_cause | {m_hit, pend_sw, 1'b0};
        seq_start = edge_no;
      end
      pend_sw = bus.SW_RST;
      for (int i = 0; i < NREQ; i++) begin
        for (int j = D - 1; j > 0; j--) hist[i][j] = hist[i][j-1];
        hist[i][0] = bus.REQ_IN[i];
        m_run = 1;
        for (int m = 0; m < MP; m++) m_run = m_run & hist[i][NS+m];
        pend_acc[i] = m_run && !hist[i][NS+MP];
      end
    end
    edge_no++;
  end

  function automatic logic [NCH-1:0] exp_ch(input int d);
    for (int k = 0; k < NCH; k++) exp_ch[k] = (d >= HOLD + (k + 1) * STEP);
  endfunction

  always @(negedge CLK) begin
    if (model_valid) begin
      int d;
      d = edge_no - 1 - seq_start;
      chk("model_ch_rst", 32'(bus.CH_RST), 32'(exp_ch(d)));
      chk("model_seq_busy", 32'(bus.SEQ_BUSY), 32'(d < HOLD + NCH * STEP));
      chk("model_rst_cause", 32'(bus.RST_CAUSE), 32'(m_cause));
    end
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge CLK);
  endtask

  int run_left [NREQ];

  initial begin
    bus.REQ_IN    = '0;
    bus.REQ_MASK  = '0;
    bus.SW_RST    = 1'b0;
    bus.CAUSE_CLR = 1'b0;
    wait_n(3);
    RST = 1'b1;

    wait_n(11); chk("por_e11", 32'(bus.CH_RST), 32'h0);
    wait_n(1);  chk("por_e12", 32'(bus.CH_RST), 32'h1);
    wait_n(4);  chk("por_e16", 32'(bus.CH_RST), 32'h3);
    wait_n(4);  chk("por_e20", 32'(bus.CH_RST), 32'h7);
    wait_n(3);  chk("por_busy_e23", 32'(bus.SEQ_BUSY), 32'h1);
    wait_n(1);  chk("por_e24", 32'(bus.CH_RST), 32'hf);
    chk("por_busy_e24", 32'(bus.SEQ_BUSY), 32'h0);
    chk("por_cause", 32'(bus.RST_CAUSE), 32'h1);

    bus.SW_RST = 1'b1;
    wait_n(1); bus.SW_RST = 1'b0;
    chk("sw_pre", 32'(bus.CH_RST), 32'hf);
    wait_n(1);
    chk("sw_assert", 32'(bus.CH_RST), 32'h0);
    chk("sw_cause", 32'(bus.RST_CAUSE), 32'h3);
    wait_n(23); chk("sw_e23_busy", 32'(bus.SEQ_BUSY), 32'h1);
    wait_n(1);  chk("sw_e24", 32'(bus.CH_RST), 32'hf);

    bus.REQ_IN[0] = 1'b1;
    wait_n(2); bus.REQ_IN[0] = 1'b0;
    wait_n(10);
    chk("short_req_ch", 32'(bus.CH_RST), 32'hf);
    chk("short_req_cause", 32'(bus.RST_CAUSE), 32'h3);

    bus.REQ_IN[0] = 1'b1;
    wait_n(5); bus.REQ_IN[0] = 1'b0;
    wait_n(1);
    chk("long_req_ch", 32'(bus.CH_RST), 32'h0);
    chk("long_req_cause", 32'(bus.RST_CAUSE), 32'h7);
    wait_n(30);
    chk("long_req_done", 32'(bus.CH_RST), 32'hf);

    bus.REQ_MASK = 2'b10;
    bus.REQ_IN[1] = 1'b1;
    wait_n(10); bus.REQ_IN[1] = 1'b0;
    wait_n(6);
    chk("masked_ch", 32'(bus.CH_RST), 32'hf);
    chk("masked_cause3", 32'(bus.RST_CAUSE[3]), 32'h0);
    bus.REQ_MASK = 2'b00;

    bus.CAUSE_CLR = 1'b1;
    wait_n(1); bus.CAUSE_CLR = 1'b0;
    chk("clr_alone", 32'(bus.RST_CAUSE), 32'h0);

    bus.CAUSE_CLR = 1'b1; bus.SW_RST = 1'b1;
    wait_n(1); bus.CAUSE_CLR = 1'b0; bus.SW_RST = 1'b0;
    wait_n(1);
    chk("clr_sw_cause", 32'(bus.RST_CAUSE), 32'h2);
    chk("clr_sw_ch", 32'(bus.CH_RST), 32'h0);

    wait_n(16); chk("mid_pre", 32'(bus.CH_RST), 32'h3);
    bus.SW_RST = 1'b1;
    wait_n(1); bus.SW_RST = 1'b0;
    wait_n(1);  chk("mid_reassert", 32'(bus.CH_RST), 32'h0);
    wait_n(11); chk("mid_e11", 32'(bus.CH_RST), 32'h0);
    wait_n(1);  chk("mid_e12", 32'(bus.CH_RST), 32'h1);

    wait_n(4);  chk("rst_mid_pre", 32'(bus.CH_RST), 32'h3);
    RST = 1'b0;
    wait_n(1);
    chk("rst_mid_ch", 32'(bus.CH_RST), 32'h0);
    chk("rst_mid_busy", 32'(bus.SEQ_BUSY), 32'h1);
    chk("rst_mid_cause", 32'(bus.RST_CAUSE), 32'h1);
    RST = 1'b1;

    for (int i = 0; i < NREQ; i++) run_left[i] = $urandom_range(1, 30);
    for (int c = 0; c < 4000; c++) begin
      @(negedge CLK);
      for (int i = 0; i < NREQ; i++) begin
        if (run_left[i] == 0) begin
          bus.REQ_IN[i] = ~bus.REQ_IN[i];
          run_left[i] = bus.REQ_IN[i] ? $urandom_range(1, 6) : $urandom_range(1, 40);
        end else begin
          run_left[i]--;
        end
      end
      bus.SW_RST    = ($urandom_range(0, 149) == 0);
      bus.CAUSE_CLR = ($urandom_range(0, 59) == 0);
      RST           = !($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 199) == 0) bus.REQ_MASK = NREQ'($urandom);
    end
    @(negedge CLK);
    RST = 1'b1;
    bus.SW_RST = 1'b0;
    bus.CAUSE_CLR = 1'b0;
    bus.REQ_IN = '0;
    wait_n(40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rst_seq_ctrl.md
# rst_seq_ctrl

Parametrised reset sequencer sitting directly behind the system reset synchronizer. It holds a set of downstream domain-reset channels in reset for a programmable hold time, then releases them one at a time in index order with a programmable stagger. It also accepts asynchronous hardware reset requests, which are synchronized and pulse-filtered, plus a software reset pulse; any accepted request re-runs the full sequence. A sticky cause register records why the last sequence ran.

## Interface
- NUM_STAGES, 2: synchronizer flops per REQ_IN bit; must be at least 2.
- NUM_CH, 4: number of sequenced reset channels; must be at least 1.
- NUM_REQ, 2: number of asynchronous reset-request inputs; must be at least 1.
- MIN_PULSE, 3: consecutive synchronized-high cycles before a request is accepted; must be at least 1.
- HOLD_CYC, 8: cycles all channels stay asserted before the release phase; range 1..255.
- STEP_DLY, 4: cycles between successive channel releases; range 1..255.
- CLK  in  1  single clock for all logic.
- RST  in  1  reset, synchronous, active-low.
- REQ_IN  in  NUM_REQ  asynchronous reset requests, active-high, any width.
- REQ_MASK  in  NUM_REQ  quasi-static; 1 = ignore the corresponding REQ_IN bit.
- SW_RST  in  1  synchronous software reset pulse, active-high.
- CAUSE_CLR  in  1  synchronous pulse that clears RST_CAUSE.
- CH_RST  out  NUM_CH  per-channel reset, active-low, registered.
- SEQ_BUSY  out  1  high while the block is in HOLD or RELEASE.
- RST_CAUSE  out  NUM_REQ+2  sticky cause flags: bit0 = RST (power-on), bit1 = SW_RST, bit 2+i = REQ_IN[i].

## Operation
- States: HOLD, RELEASE, RUN. Internal counter is 8 bits; channel index is clog2(NUM_CH) bits, minimum 1.
- Reset (RST=0 at an edge): state HOLD; counter and index 0; CH_RST all 0; SEQ_BUSY 1; RST_CAUSE = 1 in bit0, all other bits 0; synchronizer and filter flops 0.
- HOLD: counter increments every cycle. When counter == HOLD_CYC-1, go to RELEASE with counter 0 and index 0.
- RELEASE: counter increments every cycle. When counter == STEP_DLY-1:
  - set CH_RST[index] to 1 and clear the counter;
  - if index == NUM_CH-1, go to RUN and clear SEQ_BUSY in the same edge;
  - otherwise increment index.
- Released channels stay at 1 until the next trigger.
- RUN: idle; SEQ_BUSY 0.
- Request filter, per REQ_IN bit:
  - the bit passes through NUM_STAGES flops;
  - a per-bit counter counts consecutive high synchronized samples and saturates at MIN_PULSE;
  - any low sample clears the counter;
  - the bit becomes accepted on the edge where the counter reaches MIN_PULSE, one-shot per high pulse.
- Trigger = SW_RST, or any accepted bit with REQ_MASK = 0. A trigger in any state, including mid-HOLD or mid-RELEASE:
  - next edge forces CH_RST all 0, state HOLD, counter and index 0, SEQ_BUSY 1;
  - the sequence restarts from the beginning.
- RST_CAUSE on a trigger: set the bit of every simultaneous source. Bits are sticky.
- CAUSE_CLR clears all RST_CAUSE bits. If a trigger occurs in the same cycle as CAUSE_CLR, the set wins for the triggering bits.
- RST has priority over everything.
- Masked requests still run through the filter but set neither a trigger nor a cause bit.

## Timing
- After RST returns high, edge 1 is the first edge that samples RST=1. CH_RST[k] rises at edge HOLD_CYC + (k+1)*STEP_DLY.
- SEQ_BUSY falls at the same edge as CH_RST[NUM_CH-1] rises.
- SW_RST sampled high at edge t: CH_RST all 0 and RST_CAUSE[1]=1 after edge t+1. The sequence then repeats the above timing, counted from edge t+1.
- REQ_IN[i] rising before edge t (unmasked, held long enough): accepted at edge t+NUM_STAGES+MIN_PULSE-1, CH_RST all 0 after the following edge.
- A REQ_IN pulse that yields fewer than MIN_PULSE high synchronized samples is ignored.
- A request held high continuously triggers exactly once. It must go low for at least one synchronized sample before it can re-trigger.

## Test plan
- Power-on, defaults: release RST → CH_RST goes 0001, 0011, 0111, 1111 at edges 12, 16, 20, 24. SEQ_BUSY falls at edge 24. RST_CAUSE = 0001.
- SW_RST pulse while in RUN → CH_RST = 0000 on the next edge, RST_CAUSE = 0011. Full re-release completes 24 edges after the trigger edge.
- REQ_IN[0] high for 2 synchronized cycles → no trigger. High for 5 cycles → exactly one trigger and RST_CAUSE[2]=1.
- REQ_MASK[1]=1 with a long REQ_IN[1] pulse → no trigger, RST_CAUSE[3] stays 0.
- SW_RST after CH_RST = 0011 (mid-RELEASE) → all channels re-asserted, counters restart, and CH_RST[0] rises again 12 edges after the re-assert edge.
- CAUSE_CLR alone → RST_CAUSE = 0. CAUSE_CLR in the same cycle as SW_RST → RST_CAUSE = 0010. RST asserted mid-RELEASE → all outputs at reset values after the next edge.
